// File: rtl/bitorder_swap_n.sv
// Lane-order reverser: collects N lanes per word into a ping-pong buffer
// and replays each completed word reversed or in arrival order.
module bitorder_swap_n #(
  parameter int LANE_W = 2,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [LANE_W-1:0] axiid,
  input  logic              rev,
  output logic              axiov,
  output logic [LANE_W-1:0] axiod,
  output logic              axiow,
  output logic              drop,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int N  = WORD_W / LANE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (N < 2 || N * LANE_W != WORD_W) begin : g_bad_params
    $error("bitorder_swap_n: WORD_W must be a multiple of LANE_W, N>=2");
  end

  logic [WORD_W-1:0] buf_q [2];
  logic [WORD_W-1:0] buf_d [2];
  logic [1:0]        mode_q, mode_d;
  logic              fsel_q, fsel_d;
  logic [IW-1:0]     fidx_q, fidx_d;
  logic              dact_q, dact_d;
  logic              dsel_q, dsel_d;
  logic [IW-1:0]     dcnt_q, dcnt_d;
  logic              ov_q, ov_d;
  logic [LANE_W-1:0] od_q, od_d;
  logic              ow_q, ow_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              done;
  logic              emit;
  logic [WORD_W-1:0] rd_word;
  logic              rd_mode;
  logic [IW-1:0]     rd_beat;
  logic [IW-1:0]     rd_slot;

  always_comb begin
    buf_d   = buf_q;
    mode_d  = mode_q;
    fsel_d  = fsel_q;
    fidx_d  = fidx_q;
    dact_d  = dact_q;
    dsel_d  = dsel_q;
    dcnt_d  = dcnt_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    ow_d    = 1'b0;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;
    done    = 1'b0;
    emit    = 1'b0;
    rd_word = buf_q[dsel_q];
    rd_mode = mode_q[dsel_q];
    rd_beat = dcnt_q;

    if (axiiv) begin
      buf_d[fsel_q][fidx_q*LANE_W +: LANE_W] = axiid;
      if (fidx_q == '0) mode_d[fsel_q] = rev;
      if (fidx_q == LAST) begin
        done   = 1'b1;
        fidx_d = '0;
        fsel_d = ~fsel_q;
      end else begin
        fidx_d = fidx_q + 1'b1;
      end
    end else if (fidx_q != '0) begin
      fidx_d         = '0;
      buf_d[fsel_q]  = '0;
      drop_d         = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    // First beat of a new word comes straight from the buffer being
    // completed, so its last lane is read from buf_d.
    if (done) begin
      emit    = 1'b1;
      rd_word = buf_d[fsel_q];
      rd_mode = mode_q[fsel_q];
      rd_beat = '0;
      dact_d  = 1'b1;
      dsel_d  = fsel_q;
      dcnt_d  = IW'(1);
    end else if (dact_q) begin
      emit   = 1'b1;
      dcnt_d = dcnt_q + 1'b1;
      if (dcnt_q == LAST) begin
        dact_d = 1'b0;
        dcnt_d = '0;
      end
    end

    rd_slot = rd_mode ? (LAST - rd_beat) : rd_beat;
    if (emit) begin
      ov_d = 1'b1;
      od_d = rd_word[rd_slot*LANE_W +: LANE_W];
      ow_d = (rd_beat == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      mode_q   <= '0;
      fsel_q   <= 1'b0;
      fidx_q   <= '0;
      dact_q   <= 1'b0;
      dsel_q   <= 1'b0;
      dcnt_q   <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ow_q     <= 1'b0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      mode_q   <= mode_d;
      fsel_q   <= fsel_d;
      fidx_q   <= fidx_d;
      dact_q   <= dact_d;
      dsel_q   <= dsel_d;
      dcnt_q   <= dcnt_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      ow_q     <= ow_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign axiov    = ov_q;
  assign axiod    = od_q;
  assign axiow    = ow_q;
  assign drop     = drop_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_bitorder_swap_n.sv
// Scoreboard bench for bitorder_swap_n: three builds (2/8, 4/16 with a
// 2-bit drop counter, 4/12) with directed words and hand-computed replies.
module tb_bitorder_swap_n;

  typedef struct {
    logic [3:0] d;
    logic       w;
    int         c;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] v;
  logic [2:0] r;
  logic [3:0] d [3];

  logic [2:0]  ov, ow, drp;
  logic [1:0]  od0;
  logic [3:0]  od1, od2;
  logic [15:0] cnt0, cnt2;
  logic [1:0]  cnt1;

  sb_t q [3][$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  int  dseen [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitorder_swap_n #(.LANE_W(2), .WORD_W(8), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .axiiv(v[0]), .axiid(d[0][1:0]), .rev(r[0]),
    .axiov(ov[0]), .axiod(od0), .axiow(ow[0]), .drop(drp[0]),
    .drop_cnt(cnt0)
  );

  bitorder_swap_n #(.LANE_W(4), .WORD_W(16), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .axiiv(v[1]), .axiid(d[1]), .rev(r[1]),
    .axiov(ov[1]), .axiod(od1), .axiow(ow[1]), .drop(drp[1]),
    .drop_cnt(cnt1)
  );

  bitorder_swap_n #(.LANE_W(4), .WORD_W(12), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .axiiv(v[2]), .axiid(d[2]), .rev(r[2]),
    .axiov(ov[2]), .axiod(od2), .axiow(ow[2]), .drop(drp[2]),
    .drop_cnt(cnt2)
  );

  always @(negedge clk) begin : mon
    sb_t        e;
    logic [3:0] odv;
    for (int i = 0; i < 3; i++) begin
      odv = (i == 0) ? {2'b00, od0} : (i == 1) ? od1 : od2;
      if (drp[i] === 1'b1) dseen[i]++;
      if (ov[i] === 1'b1) begin
        nvec++;
        if (q[i].size() == 0) begin
          nerr++;
          $display("FAIL out%0d unexpected beat d=%0h cyc=%0d",
                   i, odv, cyc);
        end else begin
          e = q[i].pop_front();
          if (odv !== e.d || ow[i] !== e.w || cyc != e.c) begin
            nerr++;
            $display("FAIL out%0d beat got d=%0h w=%0b cyc=%0d want d=%0h w=%0b cyc=%0d",
                     i, odv, ow[i], cyc, e.d, e.w, e.c);
          end
        end
      end else if (ow[i] === 1'b1) begin
        nvec++;
        nerr++;
        $display("FAIL out%0d axiow without axiov cyc=%0d", i, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(int i, logic [3:0] dv, logic rv);
    v[i] = 1'b1;
    d[i] = dv;
    r[i] = rv;
    step();
  endtask

  task automatic idle(int i, int n);
    v[i] = 1'b0;
    repeat (n) step();
  endtask

  // Call right before driving the last lane of a word.
  task automatic exp(int i, int n, logic [3:0] e0, logic [3:0] e1,
                     logic [3:0] e2, logic [3:0] e3);
    logic [3:0] e [4];
    int nl;
    nl = (i == 2) ? 3 : 4;
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < n; k++)
      q[i].push_back('{d: e[k], w: (k == nl - 1), c: cyc + 1 + k});
  endtask

  task automatic chk(string nm, int got, int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    v = '0;
    r = '0;
    for (int i = 0; i < 3; i++) d[i] = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_axiov", int'(ov[0]), 0);
    chk("rst_axiod", int'(od0), 0);
    chk("rst_axiow", int'(ow[0]), 0);
    chk("rst_drop", int'(drp[0]), 0);
    chk("rst_drop_cnt", int'(cnt0), 0);

    lane(0, 3, 1); lane(0, 2, 1); lane(0, 1, 1);
    exp(0, 4, 0, 1, 2, 3);
    lane(0, 0, 1);
    idle(0, 6);

    lane(0, 0, 1); lane(0, 1, 1); lane(0, 2, 1);
    exp(0, 4, 3, 2, 1, 0);
    lane(0, 3, 1);
    lane(0, 3, 1); lane(0, 3, 1); lane(0, 0, 1);
    exp(0, 4, 0, 0, 3, 3);
    lane(0, 0, 1);
    idle(0, 6);

    lane(0, 1, 1); lane(0, 2, 1);
    idle(0, 1);
    lane(0, 1, 1); lane(0, 1, 1); lane(0, 2, 1);
    exp(0, 4, 2, 2, 1, 1);
    lane(0, 2, 1);
    idle(0, 6);
    chk("drop_pulses", dseen[0], 1);
    chk("drop_cnt_one", int'(cnt0), 1);

    lane(0, 0, 0); lane(0, 1, 0); lane(0, 2, 0);
    exp(0, 4, 0, 1, 2, 3);
    lane(0, 3, 0);
    lane(0, 0, 1); lane(0, 1, 1); lane(0, 2, 1);
    exp(0, 4, 3, 2, 1, 0);
    lane(0, 3, 1);
    idle(0, 6);

    lane(0, 1, 0); lane(0, 2, 1); lane(0, 3, 1);
    exp(0, 4, 1, 2, 3, 0);
    lane(0, 0, 1);
    idle(0, 6);

    lane(0, 2, 1); lane(0, 1, 1); lane(0, 3, 1);
    exp(0, 2, 0, 3, 1, 2);
    lane(0, 0, 1);
    idle(0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_axiov", int'(ov[0]), 0);
    chk("rst_mid_drop_cnt", int'(cnt0), 0);
    idle(0, 4);
    chk("rst_no_drop", dseen[0], 1);

    lane(0, 1, 1); lane(0, 2, 1); lane(0, 3, 1);
    exp(0, 4, 0, 3, 2, 1);
    lane(0, 0, 1);
    idle(0, 6);

    lane(1, 4'hA, 1); lane(1, 4'hB, 1); lane(1, 4'hC, 1);
    exp(1, 4, 4'hD, 4'hC, 4'hB, 4'hA);
    lane(1, 4'hD, 1);
    idle(1, 6);

    repeat (3) begin
      lane(1, 4'h1, 0);
      idle(1, 1);
    end
    idle(1, 1);
    chk("cnt_w2_three", int'(cnt1), 3);
    repeat (2) begin
      lane(1, 4'h1, 0);
      idle(1, 1);
    end
    idle(1, 1);
    chk("cnt_w2_sat", int'(cnt1), 3);
    chk("cnt_w2_pulses", dseen[1], 5);

    lane(2, 4'h5, 1); lane(2, 4'h6, 1);
    exp(2, 3, 4'h7, 4'h6, 4'h5, 4'h0);
    lane(2, 4'h7, 1);
    lane(2, 4'h8, 0); lane(2, 4'h9, 0);
    exp(2, 3, 4'h8, 4'h9, 4'hA, 4'h0);
    lane(2, 4'hA, 0);
    idle(2, 6);

    for (int i = 0; i < 3; i++)
      chk($sformatf("sb%0d_drained", i), q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bitorder_swap_n.md
Name: bitorder_swap_n

Overview:
- Parametrised lane-order reverser for the dibit/nibble streaming datapath, and the successor to the fixed 2-bit/8-bit dibit reorderer.
- Collects WORD_W/LANE_W lanes from a valid-only stream into a ping-pong buffer, then replays each completed word.
- Replay order is either reversed (last-arrived lane first) or original, selected per word.
- Adds partial-word drop detection, a saturating drop counter and a word-end marker.
- Sits between the PHY-side lane receiver and the byte-domain consumers, such as CRC and framing.

Parameters:
- LANE_W, 2, bits per stream beat; must be ≥1.
- WORD_W, 8, bits per word; must be a multiple of LANE_W.
- N (localparam), WORD_W/LANE_W, lanes per word; must be ≥2 (checked at elaboration).
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- axiiv  in  1  input lane valid
- axiid  in  LANE_W  input lane data
- rev  in  1  1 = reverse lane order, 0 = pass in arrival order; sampled on the first lane of each word
- axiov  out  1  output lane valid
- axiod  out  LANE_W  output lane data
- axiow  out  1  high with the final lane of each output word
- drop  out  1  one-cycle pulse when a partial word is discarded
- drop_cnt  out  CNT_W  count of discarded partial words; saturates at all-ones

Behaviour:
- Reset: one clock and a synchronous active-high reset, on ports clk and rst respectively; reset is sampled on the clk rising edge.
  - Reset clears both buffers, both counters, the fill/drain select, the latched mode and drop_cnt.
  - Outputs after reset: axiov=0, axiod=0, axiow=0, drop=0, drop_cnt=0.
  - Reset asserted mid-fill or mid-drain aborts everything on the next edge. No lane of an aborted word is ever emitted, and drop is not pulsed.
- Fill side:
  - Each cycle with axiiv=1 writes axiid into fill-buffer slot fill_idx (0..N-1), then increments fill_idx.
  - When fill_idx=0, rev is latched into that buffer's mode bit.
  - The cycle the lane at fill_idx=N-1 is written: the buffer is marked complete, fill_idx wraps to 0, and the select toggles so the next lane goes into the other buffer.
- Drain side:
  - A complete buffer drains over exactly N consecutive cycles, starting the cycle after its last lane was accepted (latency 1 cycle from last input lane to first output lane).
  - rev latched 1: output slot order is N-1, N-2, … 0.
  - rev latched 0: output slot order is 0 … N-1.
  - axiov=1 on every drain cycle. axiow=1 only on the N-th drain cycle.
  - axiov=0 and axiow=0 when idle. axiod holds its last value when idle (don't-care).
- Throughput:
  - Fill takes at least N cycles per word, so drain always finishes before the next buffer completes. No overflow and no backpressure.
  - Back-to-back words produce a gapless output stream.
  - A word that completes on the same cycle as the previous word's final drain lane begins draining on the next cycle with no bubble.
- Gaps and drops:
  - axiiv=0 with fill_idx=0 is an idle gap; no effect.
  - axiiv=0 with fill_idx≠0 discards the partial word: fill_idx←0 and the fill buffer is cleared.
  - On that discard, drop pulses for 1 cycle and drop_cnt increments, or holds if already all-ones.
  - A drain already in progress continues unaffected by a discard.
- Width rules:
  - Slot k occupies buffer bits [k*LANE_W +: LANE_W].
  - drop_cnt increment is a CNT_W-bit add gated by the saturation check.

Test Plan:
- Reverse mode, LANE_W=2, WORD_W=8, rev=1: axiid 3,2,1,0 on cycles 0–3 with axiiv=1 → axiov high cycles 4–7, axiod 0,1,2,3, axiow only at cycle 7, drop never asserted.
- Back-to-back words: 8 continuous lanes 0,1,2,3,3,3,0,0 with rev=1 → 8 contiguous valid outputs 3,2,1,0,0,0,3,3, axiow at output beats 4 and 8, no gap.
- Partial-word drop: lanes 1,2 then axiiv=0 for 1 cycle, then full word 1,1,2,2 → drop pulses once, drop_cnt=1, only output 2,2,1,1.
  - Repeat with drop_cnt preloaded via 65535 drops (or CNT_W=2 build with 4 drops) → counter sticks at max.
- Pass-through and per-word mode: rev=0 for word 0,1,2,3 then rev=1 for word 0,1,2,3 → outputs 0,1,2,3 then 3,2,1,0.
  - Toggle rev mid-word → the mode from the first lane is used.
- Reset mid-drain: complete one word, assert rst on output beat 2 → from the next cycle axiov=0, drop_cnt=0.
  - A fresh word after reset emits correctly at latency 1.
- Alternate parameters: LANE_W=4, WORD_W=16, rev=1, nibbles A,B,C,D → D,C,B,A, axiow on the 4th beat.
  - WORD_W=12 with LANE_W=4 (N=3) → 3-beat words, axiow on every 3rd beat.
